// File: rtl/fsmc_pkg.sv
// Shared register map and bit positions for the FSMC register bank.
package fsmc_pkg;

  // Register indices presented on cs by fsmc_interface
  localparam logic [3:0] REG_CTRL    = 4'h0;
  localparam logic [3:0] REG_STATUS  = 4'h1;
  localparam logic [3:0] REG_SCRATCH = 4'h2;
  localparam logic [3:0] REG_FIFO    = 4'h3;
  localparam logic [3:0] REG_IRQCLR  = 4'h4;
  localparam logic [3:0] REG_ID      = 4'h5;

  // CTRL bit positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  localparam int CTRL_IRQEN_BIT = 2;

  // STATUS bit positions (fill count lives in [7:0])
  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_OVF_BIT   = 10;

  // IRQCLR bit that clears the sticky overflow flag
  localparam int IRQCLR_OVF_BIT = 0;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush, used as the MCU read queue.
module sync_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_head,
  output logic [CW-1:0]     o_count,
  output logic              o_empty,
  output logic              o_full
);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  // Requests that would overrun or underrun are silently dropped here
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(FIFO_DEPTH));
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointer and occupancy tracking; flush takes priority over push and pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset because the empty flag masks the head
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fsmc_reg_bank.sv
// Register bank and producer FIFO sitting behind fsmc_interface, with MCU interrupt.
module fsmc_reg_bank
  import fsmc_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                FIFO_DEPTH = 16,
  parameter logic [DATA_W-1:0] ID_VALUE   = 16'hFA01
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        cs,
  input  logic              state,
  input  logic [DATA_W-1:0] bus_wdata,
  input  logic              noe_n,
  output logic [DATA_W-1:0] bus_rdata,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ctrl_en,
  output logic              irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              r_state_d;
  logic              r_noe_s1;
  logic              r_noe_s2;
  logic              r_noe_d;
  logic              r_enable;
  logic              r_irq_en;
  logic              r_flush_pend;
  logic              r_overflow;
  logic [DATA_W-1:0] r_scratch;
  logic [DATA_W-1:0] r_rdata;
  logic              r_irq;

  logic              w_commit;
  logic              w_wr_ctrl;
  logic              w_wr_scratch;
  logic              w_ovf_clr;
  logic              w_pop;
  logic              w_push;
  logic              w_ovf_evt;
  logic [DATA_W-1:0] w_head;
  logic [CW-1:0]     w_count;
  logic              w_empty;
  logic              w_full;
  logic [DATA_W-1:0] w_rdata_next;

  // A write lands when the write-data phase ends (state falls)
  assign w_commit     = r_state_d & ~state;
  assign w_wr_ctrl    = w_commit & (cs == REG_CTRL);
  assign w_wr_scratch = w_commit & (cs == REG_SCRATCH);
  assign w_ovf_clr    = w_commit & (cs == REG_IRQCLR) & bus_wdata[IRQCLR_OVF_BIT];

  // A read completes on the synchronised rising edge of NOE; popping an empty FIFO is harmless
  assign w_pop = r_noe_s2 & ~r_noe_d & (cs == REG_FIFO) & ~w_empty;

  // No bypass: a full FIFO refuses a word even if a pop happens in the same cycle
  assign in_ready  = r_enable & ~w_full & ~r_flush_pend;
  assign w_push    = in_valid & in_ready;
  assign w_ovf_evt = in_valid & r_enable & w_full;

  assign ctrl_en   = r_enable;
  assign irq       = r_irq;
  assign bus_rdata = r_rdata;

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (r_flush_pend),
    .i_data  (in_data),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Write-phase history and NOE synchroniser; NOE idles high so the sync chain resets to 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state_d <= 1'b0;
      r_noe_s1  <= 1'b1;
      r_noe_s2  <= 1'b1;
      r_noe_d   <= 1'b1;
    end else begin
      r_state_d <= state;
      r_noe_s1  <= noe_n;
      r_noe_s2  <= r_noe_s1;
      r_noe_d   <= r_noe_s2;
    end
  end

  // Writable registers; flush is a one-cycle request consumed by the FIFO the cycle after commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable     <= 1'b0;
      r_irq_en     <= 1'b0;
      r_flush_pend <= 1'b0;
      r_scratch    <= '0;
    end else begin
      r_flush_pend <= w_wr_ctrl & bus_wdata[CTRL_FLUSH_BIT];
      if (w_wr_ctrl) begin
        r_enable <= bus_wdata[CTRL_EN_BIT];
        r_irq_en <= bus_wdata[CTRL_IRQEN_BIT];
      end
      if (w_wr_scratch) r_scratch <= bus_wdata;
    end
  end

  // Sticky overflow; a new overflow in the same cycle as a clear wins so no event is lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_overflow <= 1'b0;
    else if (w_ovf_evt)  r_overflow <= 1'b1;
    else if (w_ovf_clr)  r_overflow <= 1'b0;
  end

  // Read mux selected by the current register index
  always_comb begin
    w_rdata_next = '0;
    case (cs)
      REG_CTRL: begin
        w_rdata_next[CTRL_EN_BIT]    = r_enable;
        w_rdata_next[CTRL_IRQEN_BIT] = r_irq_en;
      end
      REG_STATUS: begin
        w_rdata_next[7:0]            = 8'(w_count);
        w_rdata_next[STAT_EMPTY_BIT] = w_empty;
        w_rdata_next[STAT_FULL_BIT]  = w_full;
        w_rdata_next[STAT_OVF_BIT]   = r_overflow;
      end
      REG_SCRATCH: w_rdata_next = r_scratch;
      REG_FIFO:    w_rdata_next = w_head;
      REG_ID:      w_rdata_next = ID_VALUE;
      default:     w_rdata_next = '0;
    endcase
  end

  // Registered read data and interrupt, refreshed every clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_rdata <= w_rdata_next;
      r_irq   <= r_irq_en & (~w_empty | r_overflow);
    end
  end

endmodule
